qed_dup_scheduler: RTL and testbench
====================================

QED_DUP_SCHEDULER -- requirements
Module: qed_dup_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the instruction counters.
REQ-002 SHALL have parameter MAX_ORIG, default 16, number of original fetches after which duplication starts automatically (1..2^CNT_W-1).
REQ-003 SHALL have parameter DRAIN_CYC, default 4, number of hold cycles between the original and duplicate phases (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port ena, input, 1, QED mode enable.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a QED sequence.
REQ-008 SHALL have port force_dup, input, 1, request to end the original phase early.
REQ-009 SHALL have port fetch_vld, input, 1, one instruction was accepted by the fetch path this cycle (inst_ren qualified by vld_out).
REQ-010 SHALL have port exec_dup, output, 1, select the duplicate instruction stream (drives the QED exec_dup input).
REQ-011 SHALL have port fetch_hold, output, 1, fetch must not issue this cycle.
REQ-012 SHALL have port busy, output, 1, sequence in progress (state not IDLE).
REQ-013 SHALL have port qed_check, output, 1, one-cycle pulse: both streams issued, register compare may run.
REQ-014 SHALL have port orig_cnt, output, CNT_W, original instructions issued in the current sequence.
REQ-015 SHALL have port dup_cnt, output, CNT_W, duplicate instructions issued in the current sequence.
REQ-016 SHALL have port err, output, 1, sticky protocol error.

Function
REQ-017 SHALL implement states IDLE, ORIG, DRAIN, DUP, CHECK.
REQ-018 IDLE -> ORIG SHALL occur when start=1 and ena=1; orig_cnt, dup_cnt, drain counter SHALL clear on this transition.
REQ-019 In ORIG, each fetch_vld SHALL increment orig_cnt by 1.
REQ-020 ORIG -> DRAIN SHALL occur when the post-increment orig_cnt equals MAX_ORIG, or when force_dup=1 and the post-increment orig_cnt is nonzero; a fetch in the same cycle as force_dup SHALL be counted.
REQ-021 force_dup with orig_cnt=0 and no fetch that cycle SHALL be ignored.
REQ-022 DRAIN SHALL last exactly DRAIN_CYC cycles, then transition to DUP.
REQ-023 In DUP, each fetch_vld SHALL increment dup_cnt; the transition DUP -> CHECK SHALL occur on the cycle in which the post-increment dup_cnt equals orig_cnt.
REQ-024 CHECK SHALL last one cycle, assert qed_check, then return to IDLE; counters SHALL hold their values until the next start.
REQ-025 exec_dup SHALL be 1 exactly in DUP; fetch_hold SHALL be 1 in DRAIN and CHECK; both SHALL be registered outputs (no combinational input-to-output path).
REQ-026 fetch_vld during DRAIN or CHECK SHALL set err and SHALL NOT change any counter.
REQ-027 start while busy SHALL be ignored; force_dup outside ORIG SHALL be ignored.
REQ-028 ena=0 in any state SHALL force IDLE on the next edge with exec_dup=0 and fetch_hold=0; counters SHALL hold; err SHALL be unaffected.
REQ-029 Counters SHALL NOT wrap; MAX_ORIG bounds orig_cnt, and dup_cnt never exceeds orig_cnt.

Reset
REQ-030 rst=1 SHALL force IDLE, exec_dup=0, fetch_hold=0, busy=0, qed_check=0, orig_cnt=0, dup_cnt=0, err=0, drain counter=0 on the next edge.
REQ-031 rst SHALL take priority over every other input, including mid-sequence (DUP or DRAIN).
REQ-032 err SHALL be cleared only by rst.

Structure
REQ-033 State encoding typedef and default parameter constants SHALL reside in the shared qed package.
REQ-034 A single sub-module qed_up_counter (width-parameterized, clear/enable) SHALL be instantiated for orig_cnt, dup_cnt and the drain counter; the FSM SHALL be in the top module.

Verification
REQ-035 ena=1, start, 16 fetches in consecutive cycles -> DRAIN for 4 cycles, exec_dup=1, 16 dup fetches -> qed_check pulse one cycle later, orig_cnt=dup_cnt=16.
REQ-036 start, 3 fetches, force_dup together with the 4th fetch -> orig_cnt=4, DRAIN entered, CHECK after the 4th dup fetch.
REQ-037 force_dup immediately after start with no fetch -> stays ORIG, orig_cnt=0.
REQ-038 fetch_vld during the 2nd DRAIN cycle -> err=1 and sticky, orig_cnt unchanged, DRAIN still 4 cycles.
REQ-039 rst asserted in DUP with dup_cnt=5 -> next cycle all outputs at reset values; ena dropped in DUP -> IDLE, exec_dup=0, counters held.
REQ-040 start during DUP -> ignored, sequence completes normally.

Source files
------------

// File: rtl/qed_dup_scheduler_pkg.sv
// rtl/qed_dup_scheduler_pkg.sv - shared QED scheduler state encoding and default parameters
package qed_dup_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORIG,
    ST_DRAIN,
    ST_DUP,
    ST_CHECK
  } qed_state_t;

  localparam int QED_CNT_W     = 8;
  localparam int QED_MAX_ORIG  = 16;
  localparam int QED_DRAIN_CYC = 4;

endpackage

// File: rtl/qed_up_counter.sv
// rtl/qed_up_counter.sv - width-parameterized up counter with sync clear/enable
// Saturates at all-ones so a misbehaving controller can never wrap it.
module qed_up_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/qed_dup_scheduler.sv
// rtl/qed_dup_scheduler.sv - QED original/duplicate instruction stream scheduler
// Runs an original fetch phase, drains, replays the same count as duplicates, then pulses qed_check.
module qed_dup_scheduler
  import qed_dup_scheduler_pkg::*;
#(
  parameter int CNT_W     = QED_CNT_W,
  parameter int MAX_ORIG  = QED_MAX_ORIG,
  parameter int DRAIN_CYC = QED_DRAIN_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             force_dup,
  input  logic             fetch_vld,
  output logic             exec_dup,
  output logic             fetch_hold,
  output logic             busy,
  output logic             qed_check,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             err
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_ORIG);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);

  qed_state_t       state, state_nxt;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] orig_inc, dup_inc;
  logic             seq_clr, orig_en, dup_en, drain_en, err_set;
  logic             exec_dup_q, fetch_hold_q;

  assign orig_inc = orig_cnt + CNT_W'(fetch_vld);
  assign dup_inc  = dup_cnt + CNT_W'(fetch_vld);

  always_comb begin
    state_nxt = state;
    seq_clr   = 1'b0;
    orig_en   = 1'b0;
    dup_en    = 1'b0;
    drain_en  = 1'b0;
    err_set   = 1'b0;
    if (!ena) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_ORIG;
            seq_clr   = 1'b1;
          end
        end
        ST_ORIG: begin
          orig_en = fetch_vld;
          // A fetch coinciding with force_dup is counted before the zero test.
          if ((fetch_vld && (orig_inc == MAX_C)) || (force_dup && (orig_inc != '0)))
            state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_en = 1'b1;
          err_set  = fetch_vld;
          if (drain_cnt == DRAIN_LAST)
            state_nxt = ST_DUP;
        end
        ST_DUP: begin
          dup_en = fetch_vld;
          if (fetch_vld && (dup_inc == orig_cnt))
            state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          err_set   = fetch_vld;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      exec_dup_q   <= 1'b0;
      fetch_hold_q <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      exec_dup_q   <= (state_nxt == ST_DUP);
      fetch_hold_q <= (state_nxt == ST_DRAIN) || (state_nxt == ST_CHECK);
      if (err_set)
        err <= 1'b1;
    end
  end

  assign exec_dup   = exec_dup_q;
  assign fetch_hold = fetch_hold_q;
  assign busy       = (state != ST_IDLE);
  assign qed_check  = (state == ST_CHECK);

  qed_up_counter #(.W(CNT_W)) u_orig_cnt (
    .clk (clk),
    .rst (rst),
    .clr (seq_clr),
    .en  (orig_en),
    .cnt (orig_cnt)
  );

  qed_up_counter #(.W(CNT_W)) u_dup_cnt (
    .clk (clk),
    .rst (rst),
    .clr (seq_clr),
    .en  (dup_en),
    .cnt (dup_cnt)
  );

  qed_up_counter #(.W(DW)) u_drain_cnt (
    .clk (clk),
    .rst (rst),
    .clr (seq_clr),
    .en  (drain_en),
    .cnt (drain_cnt)
  );

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb/tb_qed_dup_scheduler.sv - scoreboard bench for qed_dup_scheduler
module tb_qed_dup_scheduler;

  localparam int CW   = 8;
  localparam int MAXO = 16;
  localparam int DRN  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ORIG  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DUP   = 3;
  localparam int P_CHECK = 4;

  logic          clk = 1'b0;
  logic          rst, ena, start, force_dup, fetch_vld;
  logic          exec_dup, fetch_hold, busy, qed_check, err;
  logic [CW-1:0] orig_cnt, dup_cnt;

  typedef struct packed {
    logic          exec_dup;
    logic          fetch_hold;
    logic          busy;
    logic          qed_check;
    logic          err;
    logic [CW-1:0] orig;
    logic [CW-1:0] dup;
  } obs_t;

  obs_t            exp_q[$];
  logic [2*CW-1:0] chk_q[$];
  int              total = 0;
  int              bad   = 0;

  int m_ph = P_IDLE;
  int m_o = 0, m_d = 0, m_left = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  qed_dup_scheduler #(.CNT_W(CW), .MAX_ORIG(MAXO), .DRAIN_CYC(DRN)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .force_dup  (force_dup),
    .fetch_vld  (fetch_vld),
    .exec_dup   (exec_dup),
    .fetch_hold (fetch_hold),
    .busy       (busy),
    .qed_check  (qed_check),
    .orig_cnt   (orig_cnt),
    .dup_cnt    (dup_cnt),
    .err        (err)
  );

  // Reference behaviour: one call per clock, returns what outputs must read after the edge.
  task automatic step(input logic r, input logic e, input logic s, input logic f, input logic v);
    obs_t x;
    rst = r; ena = e; start = s; force_dup = f; fetch_vld = v;
    if (r) begin
      m_ph = P_IDLE; m_o = 0; m_d = 0; m_left = 0; m_err = 1'b0;
    end else if (!e) begin
      m_ph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE: if (s) begin m_ph = P_ORIG; m_o = 0; m_d = 0; end
        P_ORIG: begin
          if (v) m_o++;
          if ((v && m_o == MAXO) || (f && m_o > 0)) begin m_ph = P_DRAIN; m_left = DRN; end
        end
        P_DRAIN: begin
          if (v) m_err = 1'b1;
          m_left--;
          if (m_left == 0) m_ph = P_DUP;
        end
        P_DUP: begin
          if (v) m_d++;
          if (v && m_d == m_o) begin
            m_ph = P_CHECK;
            chk_q.push_back({CW'(m_o), CW'(m_d)});
          end
        end
        default: begin
          if (v) m_err = 1'b1;
          m_ph = P_IDLE;
        end
      endcase
    end
    x.exec_dup   = (m_ph == P_DUP);
    x.fetch_hold = (m_ph == P_DRAIN) || (m_ph == P_CHECK);
    x.busy       = (m_ph != P_IDLE);
    x.qed_check  = (m_ph == P_CHECK);
    x.err        = m_err;
    x.orig       = CW'(m_o);
    x.dup        = CW'(m_d);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin : monitor
    obs_t            e, a;
    logic [2*CW-1:0] c;
    forever begin
      @(posedge clk);
      #1;
      a = '{exec_dup, fetch_hold, busy, qed_check, err, orig_cnt, dup_cnt};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got dup=%b hold=%b busy=%b chk=%b err=%b o=%0d d=%0d expected dup=%b hold=%b busy=%b chk=%b err=%b o=%0d d=%0d",
                   $time, a.exec_dup, a.fetch_hold, a.busy, a.qed_check, a.err, a.orig, a.dup,
                   e.exec_dup, e.fetch_hold, e.busy, e.qed_check, e.err, e.orig, e.dup);
        end
      end
      if (qed_check === 1'b1) begin
        total++;
        if (chk_q.size() == 0) begin
          bad++;
          $display("FAIL check_event @%0t: got unexpected qed_check expected none", $time);
        end else begin
          c = chk_q.pop_front();
          if ({orig_cnt, dup_cnt} !== c) begin
            bad++;
            $display("FAIL check_counts @%0t: got %0d/%0d expected %0d/%0d",
                     $time, orig_cnt, dup_cnt, c[2*CW-1:CW], c[CW-1:0]);
          end
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; ena = 1'b0; start = 1'b0; force_dup = 1'b0; fetch_vld = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_outputs", 32'({exec_dup, fetch_hold, busy, qed_check, err, orig_cnt, dup_cnt}), 32'd0);

    // full-length sequence
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(16);
    chk("max_orig_hold", 32'(fetch_hold), 32'd1);
    chk("max_orig_cnt", 32'(orig_cnt), 32'd16);
    idle(4);
    chk("drain_to_dup", 32'(exec_dup), 32'd1);
    fetch(16);
    chk("full_check", 32'(qed_check), 32'd1);
    chk("full_dup_cnt", 32'(dup_cnt), 32'd16);
    idle(1);
    chk("full_idle", 32'({busy, orig_cnt}), 32'({1'b0, 8'd16}));

    // force_dup with the 4th fetch
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("force_orig_cnt", 32'({fetch_hold, orig_cnt}), 32'({1'b1, 8'd4}));
    idle(4);
    fetch(3);
    chk("force_no_early_check", 32'(qed_check), 32'd0);
    fetch(1);
    chk("force_check", 32'(qed_check), 32'd1);
    idle(1);

    // force_dup with nothing fetched is ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("force_empty", 32'({busy, fetch_hold, orig_cnt}), 32'({1'b1, 1'b0, 8'd0}));
    fetch(2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    fetch(2);
    idle(1);

    // fetch in the 2nd drain cycle
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_err", 32'({err, orig_cnt}), 32'({1'b1, 8'd6}));
    idle(1);
    chk("drain_still_hold", 32'(fetch_hold), 32'd1);
    idle(1);
    chk("drain_len", 32'(exec_dup), 32'd1);
    fetch(6);
    idle(1);
    chk("err_sticky", 32'(err), 32'd1);

    // reset during DUP, then ena drop during DUP
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    fetch(5);
    chk("dup_five", 32'(dup_cnt), 32'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_in_dup", 32'({exec_dup, fetch_hold, busy, qed_check, err, orig_cnt, dup_cnt}), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    fetch(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ena_drop", 32'({exec_dup, busy, orig_cnt, dup_cnt}), 32'({2'b00, 8'd2, 8'd1}));
    idle(2);

    // start during DUP is ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    fetch(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("start_in_dup", 32'({exec_dup, dup_cnt}), 32'({1'b1, 8'd3}));
    fetch(1);
    chk("start_in_dup_check", 32'(qed_check), 32'd1);
    idle(1);

    // randomized traffic
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(299) == 0), 1'($urandom_range(59) != 0),
           1'($urandom_range(7) == 0), 1'($urandom_range(15) == 0),
           1'($urandom_range(1)));
    end
    idle(3);
    @(posedge clk);
    #2;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("check_queue_drained", 32'(chk_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
